// File: rtl/ladder_pkg.sv
// ladder_pkg: shared states, defaults and beat indices for the ladder sequencer.
// Config macro LADDER_SEQ_LEADZERO_SKIP_EN selects leading-zero skipping (SKIP_EN=1);
// undefined gives the constant-time full-length ladder (SKIP_EN=0).
package ladder_pkg;
  localparam int M_DEF = 163;
  localparam int POST_DEF = 110;
  localparam logic [1:0] BEAT_PX = 2'd0;
  localparam logic [1:0] BEAT_PY = 2'd1;
  localparam logic [1:0] BEAT_K = 2'd2;
  localparam logic [1:0] BEAT_B = 2'd3;
`ifdef LADDER_SEQ_LEADZERO_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_STEP, S_FINAL, S_POST, S_DONE} state_t;
endpackage

// File: rtl/ladder_kscan.sv
// ladder_kscan: scalar shift register, previous-bit flag, step counter and leading-zero scan.
// Ports: i_load/i_din load k; i_scan_start arms the counter and clears prev; i_scan shifts
// during the leading-zero scan; i_shift consumes one bit on step acceptance.
// o_bit = current scalar bit, o_prev = previously scanned bit, o_steps_zero, o_zero (k_sh==0).
// Config macro LADDER_SEQ_LEADZERO_SKIP_EN (via ladder_pkg::SKIP_EN) sets the counter start.
module ladder_kscan
  import ladder_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [M-1:0] i_din,
  input  logic         i_scan_start,
  input  logic         i_scan,
  input  logic         i_shift,
  output logic         o_bit,
  output logic         o_prev,
  output logic         o_steps_zero,
  output logic         o_zero
);
  localparam int SW = $clog2(M + 1);
  // In skip mode the counter tracks the index of the bit currently at the MSB,
  // so when the leading one appears it already holds the leading-one index.
  localparam logic [SW-1:0] START = SKIP_EN ? SW'(M - 1) : SW'(M);
  logic [M-1:0] r_k;
  logic r_prev;
  logic [SW-1:0] r_steps;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_k <= '0;
      r_prev <= 1'b0;
      r_steps <= '0;
    end else begin
      if (i_load) r_k <= i_din;
      else if (i_scan || i_shift) r_k <= {r_k[M-2:0], 1'b0};
      if (i_scan_start) begin
        r_prev <= 1'b0;
        r_steps <= START;
      end else if (i_shift) begin
        r_prev <= r_k[M-1];
        r_steps <= r_steps - SW'(1);
      end else if (i_scan && !r_k[M-1] && !o_steps_zero) r_steps <= r_steps - SW'(1);
    end
  assign o_bit = r_k[M-1];
  assign o_prev = r_prev;
  assign o_steps_zero = r_steps == '0;
  assign o_zero = r_k == '0;
endmodule

// File: rtl/ladder_seq.sv
// ladder_seq: Montgomery-ladder sequencer; loads Px,Py,k,b beats, offers swap steps, waits POST_CYC.
// Ports: clk, rst (async high); data_en/din operand beats; busy, cores_en, opt_Rx/Ry/Rb to cores;
// step_valid/step_swap/step_last with step_ready handshake; done and err completion pulses.
// Config macro LADDER_SEQ_LEADZERO_SKIP_EN: skip leading zeros of k and flag k==0 on err.
module ladder_seq
  import ladder_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int POST_CYC = POST_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_en,
  input  logic [M-1:0] din,
  output logic         busy,
  output logic         cores_en,
  output logic [M-1:0] opt_Rx,
  output logic [M-1:0] opt_Ry,
  output logic [M-1:0] opt_Rb,
  output logic         step_valid,
  output logic         step_swap,
  output logic         step_last,
  input  logic         step_ready,
  output logic         done,
  output logic         err
);
  localparam int PW = $clog2(POST_CYC + 1);
  state_t r_state, w_next;
  logic [1:0] r_beat;
  logic [M-1:0] r_px, r_py;
  logic [PW-1:0] r_post;
  logic r_gap, r_cores_en, r_err;
  logic w_beat, w_last_beat, w_accept, w_shift, w_bit, w_prev, w_steps_zero, w_zero;
  assign w_beat = data_en && (r_state == S_IDLE || r_state == S_LOAD);
  assign w_last_beat = w_beat && r_beat == BEAT_B;
  // r_gap forces one valid-low cycle after every accepted step
  assign step_valid = (r_state == S_STEP && !r_gap) || r_state == S_FINAL;
  assign step_last = r_state == S_FINAL;
  assign step_swap = step_last ? w_prev : step_valid && (w_bit ^ w_prev);
  assign w_accept = step_valid && step_ready;
  assign w_shift = r_state == S_STEP && w_accept;
  assign busy = r_state != S_IDLE;
  assign cores_en = r_cores_en;
  assign done = r_state == S_DONE;
  assign err = SKIP_EN && done && r_err;
  ladder_kscan #(.M(M)) u_kscan (
    .clk(clk),
    .rst(rst),
    .i_load(w_beat && r_beat == BEAT_K),
    .i_din(din),
    .i_scan_start(w_last_beat),
    .i_scan(SKIP_EN && r_state == S_SCAN),
    .i_shift(w_shift),
    .o_bit(w_bit),
    .o_prev(w_prev),
    .o_steps_zero(w_steps_zero),
    .o_zero(w_zero)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_beat ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = w_last_beat ? S_SCAN : S_LOAD;
      // MSB of 1 is the leading one: it is consumed by this cycle's shift
      S_SCAN:  w_next = !SKIP_EN ? S_STEP : w_bit ? (w_steps_zero ? S_FINAL : S_STEP) : (w_zero && w_steps_zero) ? S_DONE : S_SCAN;
      S_STEP:  w_next = (r_gap && w_steps_zero) ? S_FINAL : S_STEP;
      S_FINAL: w_next = w_accept ? S_POST : S_FINAL;
      S_POST:  w_next = r_post == PW'(POST_CYC - 1) ? S_DONE : S_POST;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_beat <= '0;
      r_px <= '0;
      r_py <= '0;
      r_post <= '0;
      r_gap <= 1'b0;
      r_cores_en <= 1'b0;
      r_err <= 1'b0;
      opt_Rx <= '0;
      opt_Ry <= '0;
      opt_Rb <= '0;
    end else begin
      r_state <= w_next;
      r_beat <= w_beat ? r_beat + 2'd1 : r_beat;
      if (w_beat && r_beat == BEAT_PX) r_px <= din;
      if (w_beat && r_beat == BEAT_PY) r_py <= din;
      r_post <= r_state == S_POST ? r_post + PW'(1) : '0;
      r_gap <= w_shift;
      r_cores_en <= w_last_beat;
      r_err <= r_state == S_SCAN && w_next == S_DONE;
      if (w_last_beat) begin
        opt_Rx <= r_px;
        opt_Ry <= r_py;
        opt_Rb <= din;
      end else if (r_state == S_DONE) begin
        opt_Rx <= '0;
        opt_Ry <= '0;
        opt_Rb <= '0;
      end
    end
endmodule

// File: tb/tb_ladder_seq.sv
// tb_ladder_seq: table-driven check of ladder_seq in the build mode selected by LADDER_SEQ_LEADZERO_SKIP_EN.
module tb_ladder_seq;
  localparam int M = 163;
  localparam int P = 110;
  logic clk = 1'b0, rst = 1'b1, data_en = 1'b0, step_ready = 1'b1;
  logic [M-1:0] din = '0;
  logic busy, cores_en, step_valid, step_swap, step_last, done, err;
  logic [M-1:0] opt_Rx, opt_Ry, opt_Rb;
  int total = 0, bad = 0;
  typedef struct {
    logic [M-1:0] k;
    int stall;
    int scan;
    int steps;
    int ones;
    logic fin;
    logic err;
  } vec_t;
  vec_t tv[6];
  ladder_seq #(.M(M), .POST_CYC(P)) dut (
    .clk(clk), .rst(rst), .data_en(data_en), .din(din), .busy(busy), .cores_en(cores_en),
    .opt_Rx(opt_Rx), .opt_Ry(opt_Ry), .opt_Rb(opt_Rb), .step_valid(step_valid),
    .step_swap(step_swap), .step_last(step_last), .step_ready(step_ready), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk1(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", n, a, e);
    end
  endtask
  task automatic chki(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  task automatic chkw(input string n, input logic [M-1:0] a, input logic [M-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic chk_idle_outputs(input string n);
    chk1(n, |{busy, cores_en, step_valid, step_swap, step_last, done, err}, 1'b0);
    chkw({n, "_opt"}, opt_Rx | opt_Ry | opt_Rb, '0);
  endtask
  task automatic load(input logic [M-1:0] px, input logic [M-1:0] py, input logic [M-1:0] k, input logic [M-1:0] b, input int gap);
    logic [M-1:0] beat[4];
    beat[0] = px;
    beat[1] = py;
    beat[2] = k;
    beat[3] = b;
    for (int i = 0; i < 4; i++) begin
      data_en = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk1("cores_en_gap", cores_en, 1'b0);
      end
      data_en = 1'b1;
      din = beat[i];
      @(negedge clk);
      if (i < 3) begin
        chk1("cores_en_early", cores_en, 1'b0);
        chk1("busy_load", busy, 1'b1);
      end
    end
  endtask
  task automatic run(input vec_t v, input int gap);
    logic [M-1:0] px, py, b;
    int cyc, scan, steps, ones, fin_at, done_at, gaps_bad, stable_bad, cores_bad, err_bad;
    logic fin_swap, err_seen, prev_acc, stalled, s0;
    px = M'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    py = M'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    b = M'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    load(px, py, v.k, b, gap);
    chk1("cores_en", cores_en, 1'b1);
    chkw("opt_Rx", opt_Rx, px);
    chkw("opt_Ry", opt_Ry, py);
    chkw("opt_Rb", opt_Rb, b);
    cyc = 0; scan = -1; steps = 0; ones = 0; fin_at = -1; done_at = -1;
    gaps_bad = 0; stable_bad = 0; cores_bad = 0; err_bad = 0;
    fin_swap = 1'b0; err_seen = 1'b0; prev_acc = 1'b0; stalled = 1'b0;
    data_en = 1'b1;
    din = '1;
    step_ready = 1'b1;
    while (done_at < 0 && cyc < 2000) begin
      if ((step_valid || done) && scan < 0) scan = cyc;
      if (step_valid && prev_acc) gaps_bad++;
      if (cyc > 0 && cores_en) cores_bad++;
      if (err && !done) err_bad++;
      if (step_valid && v.stall > 0 && !stalled) begin
        stalled = 1'b1;
        s0 = step_swap;
        step_ready = 1'b0;
        for (int i = 0; i < v.stall; i++) begin
          @(negedge clk);
          cyc++;
          if (!(step_valid && step_swap === s0)) stable_bad++;
        end
        step_ready = 1'b1;
      end
      prev_acc = step_valid && step_ready;
      if (step_valid && step_last) begin
        fin_at = cyc;
        fin_swap = step_swap;
      end else if (step_valid) begin
        steps++;
        ones += int'(step_swap);
      end
      if (done) begin
        done_at = cyc;
        err_seen = err;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    data_en = 1'b0;
    chk1("done_timeout", done_at >= 0, 1'b1);
    chki("scan_cycles", scan, v.scan);
    chki("steps", steps, v.steps);
    chki("swap_ones", ones, v.ones);
    chk1("err", err_seen, v.err);
    chk1("final_seen", fin_at >= 0, !v.err);
    if (!v.err) begin
      chk1("final_swap", fin_swap, v.fin);
      chki("done_latency", done_at - fin_at, P + 1);
    end
    chki("valid_gap", gaps_bad, 0);
    chki("stall_stable", stable_bad, 0);
    chki("cores_en_once", cores_bad, 0);
    chki("err_without_done", err_bad, 0);
    @(negedge clk);
    chk_idle_outputs("after_done");
  endtask
  initial begin
    logic [M-1:0] kmsb, kall;
    int n;
    kmsb = {1'b1, {(M - 1){1'b0}}};
    kall = '1;
`ifdef LADDER_SEQ_LEADZERO_SKIP_EN
    tv[0] = '{M'(5), 10, 161, 2, 1, 1'b1, 1'b0};
    tv[1] = '{M'(0), 0, 163, 0, 0, 1'b0, 1'b1};
    tv[2] = '{M'(1), 0, 163, 0, 0, 1'b0, 1'b0};
    tv[3] = '{kall, 0, 1, 162, 1, 1'b1, 1'b0};
    tv[4] = '{kmsb, 0, 1, 162, 0, 1'b0, 1'b0};
    tv[5] = '{M'(6), 0, 161, 2, 2, 1'b0, 1'b0};
`else
    tv[0] = '{M'(5), 10, 1, 163, 3, 1'b1, 1'b0};
    tv[1] = '{M'(0), 0, 1, 163, 0, 1'b0, 1'b0};
    tv[2] = '{M'(1), 0, 1, 163, 1, 1'b1, 1'b0};
    tv[3] = '{kall, 0, 1, 163, 1, 1'b1, 1'b0};
    tv[4] = '{kmsb, 0, 1, 163, 2, 1'b0, 1'b0};
    tv[5] = '{M'(6), 0, 1, 163, 2, 1'b0, 1'b0};
`endif
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("idle_state");
    for (int i = 0; i < 6; i++) run(tv[i], i % 3);
    load(M'(11), M'(22), M'(5), M'(33), 3);
    chk1("cores_en_gapped", cores_en, 1'b1);
    data_en = 1'b0;
    n = 0;
    while (!step_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk1("step_before_rst", step_valid, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done || busy || step_valid || err) n++;
    end
    chki("quiet_after_rst", n, 0);
    run(tv[5], 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
